// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller constants: default widths and burst-reader state encoding.
// The FIFO side imports the same package so both ends agree on word sizes.
package mem_ctrl_pkg;

    localparam int DATA_W_DFLT = 256;
    localparam int ADDR_W_DFLT = 10;
    localparam int LEN_W_DFLT  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } burst_state_e;

endpackage

// File: rtl/mem_burst_rd_256.sv
// Burst reader: walks a word-address range in memory and pushes each word into a
// downstream 256-to-64 FIFO, at most one read outstanding at a time.
module mem_burst_rd_256
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DFLT,
    parameter int ADDR_WIDTH = ADDR_W_DFLT,
    parameter int LEN_WIDTH  = LEN_W_DFLT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_vld,
    output logic                  cmd_rdy,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  fifo_wr,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_full
);

    burst_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_inflight;
    logic                  w_issue;

    // fifo_full leaves enough headroom that the write one cycle later never
    // needs to be re-qualified; gating on r_inflight caps rate at one word per two cycles.
    assign w_issue  = (r_state == S_RUN) && (r_remaining != '0) && !fifo_full && !r_inflight;

    assign cmd_rdy  = (r_state == S_IDLE);
    assign busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done     = (r_state == S_DONE);
    assign mem_rd   = w_issue;
    assign mem_addr = r_addr;
    assign fifo_wr  = r_inflight;
    assign fifo_din = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            case (r_state)
                S_IDLE: begin
                    if (cmd_vld) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= cmd_len;
                        r_state     <= (cmd_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end else if (r_remaining == '0) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!r_inflight)
                        r_state <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_rd_256.sv
// Scoreboard bench for mem_burst_rd_256: expected addresses/data queued at command
// accept, popped as mem_rd / fifo_wr appear; plus cycle-exact pattern checks.
module tb_mem_burst_rd_256;
    import mem_ctrl_pkg::*;

    localparam int DW = 256;
    localparam int AW = 10;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          busy;
    logic          done;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          fifo_wr;
    logic [DW-1:0] fifo_din;
    logic          fifo_full;
    logic          ff_force;
    logic          model_en;
    int            occ;
    int            occ_peak;

    int n_chk  = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];

    always #5 clk = ~clk;

    mem_burst_rd_256 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .busy(busy), .done(done),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_full(fifo_full)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = '0;
        for (int i = 0; i < DW/32; i++)
            v[i*32 +: 32] = {6'(i), 16'hBEEF ^ 16'(i * 7), a};
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // memory: data valid the cycle after the read strobe
    always @(posedge clk) if (mem_rd) mem_rdata <= pat(mem_addr);

    // downstream 256-to-64 FIFO occupancy, in 64-bit words, drained one per cycle
    assign fifo_full = ff_force | (model_en && occ >= 16);
    always @(posedge clk) begin
        if (!model_en) occ <= 0;
        else occ <= occ + (fifo_wr ? 4 : 0) - ((occ > 0) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (occ > occ_peak) occ_peak = occ;
            if (fifo_full) chk("rd_while_full", {255'd0, mem_rd}, '0);
            if (mem_rd) begin
                if (q_addr.size() == 0) chk("unexpected_rd", 1, 0);
                else chk("mem_addr", {246'd0, mem_addr}, {246'd0, q_addr.pop_front()});
            end
            if (fifo_wr) begin
                wr_cnt++;
                if (q_data.size() == 0) chk("unexpected_wr", 1, 0);
                else chk("fifo_din", fifo_din, q_data.pop_front());
            end
            if (done) done_cnt++;
        end
    end

    task automatic issue(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("rdy_timeout", 0, 1);
        cmd_vld  = 1'b1;
        cmd_addr = a;
        cmd_len  = l;
        @(posedge clk);
        for (int i = 0; i < int'(l); i++) begin
            q_addr.push_back(AW'(a + AW'(i)));
            q_data.push_back(pat(AW'(a + AW'(i))));
        end
        #1 cmd_vld = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk(tag, 0, 1);
        @(negedge clk);
    endtask

    task automatic collect(output logic [11:0] r, output logic [11:0] w, output logic [11:0] d);
        r = '0; w = '0; d = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            r[k] = mem_rd;
            w[k] = fifo_wr;
            d[k] = done;
        end
    endtask

    initial begin
        logic [11:0] m_rd, m_wr, m_dn;
        int w0, d0, stall_wr;

        rst_n = 1'b0; cmd_vld = 1'b0; cmd_addr = '0; cmd_len = '0;
        ff_force = 1'b0; model_en = 1'b0; occ_peak = 0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_rdy", {255'd0, cmd_rdy}, 1);
        chk("rst_busy",    {255'd0, busy},    0);
        chk("rst_done",    {255'd0, done},    0);
        chk("rst_mem_rd",  {255'd0, mem_rd},  0);
        chk("rst_mem_addr", {246'd0, mem_addr}, 0);
        chk("rst_fifo_wr", {255'd0, fifo_wr}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // basic len=4: read every other cycle, write one cycle later, done at cycle 9
        w0 = wr_cnt; d0 = done_cnt;
        issue(10'h010, 8'd4);
        collect(m_rd, m_wr, m_dn);
        chk("t1_rd_cycles",   {244'd0, m_rd}, {244'd0, 12'h055});
        chk("t1_wr_cycles",   {244'd0, m_wr}, {244'd0, 12'h0AA});
        chk("t1_done_cycles", {244'd0, m_dn}, {244'd0, 12'h200});
        chk("t1_wr_count",   wr_cnt - w0,   4);
        chk("t1_done_count", done_cnt - d0, 1);

        // len=0: done the cycle after accept, no traffic
        w0 = wr_cnt;
        issue(10'h055, 8'd0);
        collect(m_rd, m_wr, m_dn);
        chk("t2_rd_cycles",   {244'd0, m_rd}, 0);
        chk("t2_wr_cycles",   {244'd0, m_wr}, 0);
        chk("t2_done_cycles", {244'd0, m_dn}, {244'd0, 12'h001});

        // address wrap 0x3FE -> 0x001
        w0 = wr_cnt; d0 = done_cnt;
        issue(10'h3FE, 8'd4);
        wait_done("t3_done_timeout", 50);
        chk("t3_wr_count",   wr_cnt - w0,   4);
        chk("t3_done_count", done_cnt - d0, 1);

        // stall: fifo_full for 10 cycles after the first read; stray command ignored
        w0 = wr_cnt; d0 = done_cnt;
        issue(10'h100, 8'd3);
        @(negedge clk);
        chk("t4_first_rd", {255'd0, mem_rd}, 1);
        @(posedge clk);
        #1 ff_force = 1'b1;
        stall_wr = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (fifo_wr) stall_wr++;
            if (k == 2) begin
                cmd_vld = 1'b1; cmd_addr = 10'h2AA; cmd_len = 8'd5;
            end
            if (k == 6) cmd_vld = 1'b0;
        end
        chk("t4_stall_wr", stall_wr, 1);
        chk("t4_stall_busy", {255'd0, busy}, 1);
        @(posedge clk);
        #1 ff_force = 1'b0;
        wait_done("t4_done_timeout", 50);
        chk("t4_wr_count",   wr_cnt - w0,   3);
        chk("t4_done_count", done_cnt - d0, 1);

        // len=16 into a draining FIFO model with 4-entry headroom
        w0 = wr_cnt; d0 = done_cnt;
        model_en = 1'b1; occ_peak = 0;
        issue(10'h200, 8'd16);
        wait_done("t5_done_timeout", 200);
        chk("t5_wr_count",   wr_cnt - w0,   16);
        chk("t5_done_count", done_cnt - d0, 1);
        chk("t5_peak_le8_entries", {255'd0, occ_peak <= 32}, 1);
        model_en = 1'b0;

        // reset the cycle after a read: in-flight data must not be written
        issue(10'h020, 8'd8);
        @(negedge clk);
        chk("t6_rd_before_rst", {255'd0, mem_rd}, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_wr_in_rst",  {255'd0, fifo_wr}, 0);
        chk("t6_rdy_in_rst", {255'd0, cmd_rdy}, 1);
        q_addr.delete();
        q_data.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_busy_after", {255'd0, busy},    0);
        chk("t6_rdy_after",  {255'd0, cmd_rdy}, 1);
        w0 = wr_cnt; d0 = done_cnt;
        issue(10'h030, 8'd2);
        wait_done("t6_done_timeout", 50);
        chk("t6_wr_count",   wr_cnt - w0,   2);
        chk("t6_done_count", done_cnt - d0, 1);
        chk("t6_q_empty", q_data.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
